// File: rtl/cdb_complete_arbiter_if.sv
// Bus bundle between the execute-stage FUs and the CDB completion arbiter.
// A transfer happens in a cycle where an FU has fu_done_i=1 (valid) and the arbiter returns fu_complete_en_o=1 (ready) for it.
interface cdb_complete_arbiter_if #(
  parameter int FU_NUM      = 4,
  parameter int CDB_NUM     = 2,
  parameter int XLEN        = 32,
  parameter int PREG_NUMBER = 64
);
  localparam int TW = $clog2(PREG_NUMBER);
  localparam int PW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

  logic [FU_NUM-1:0]           fu_done_i;
  logic [FU_NUM-1:0][XLEN-1:0] fu_result_i;
  logic [FU_NUM-1:0][TW-1:0]   fu_dest_reg_i;
  logic [FU_NUM-1:0]           fu_wr_en_i;
  logic [1:0]                  branch_recover_i;
  logic [FU_NUM-1:0]           fu_complete_en_o;
  logic [CDB_NUM-1:0]          cdb_valid_o;
  logic [CDB_NUM-1:0][TW-1:0]  cdb_tag_o;
  logic [CDB_NUM-1:0][XLEN-1:0] cdb_value_o;
  logic [CDB_NUM-1:0]          cdb_wr_en_o;
  logic [PW-1:0]               ptr_o;

  modport master (
    output fu_done_i, fu_result_i, fu_dest_reg_i, fu_wr_en_i, branch_recover_i,
    input  fu_complete_en_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_wr_en_o, ptr_o
  );

  modport slave (
    input  fu_done_i, fu_result_i, fu_dest_reg_i, fu_wr_en_i, branch_recover_i,
    output fu_complete_en_o, cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_wr_en_o, ptr_o
  );
endinterface

// File: rtl/cdb_complete_arbiter.sv
// Round-robin CDB arbiter: same-cycle grants to done FUs, registered broadcast lanes one cycle later.
// Optional macro CDB_FU0_PRIORITY_EN gives FU0 fixed ownership of lane 0 when it is done.
module cdb_complete_arbiter #(
  parameter int FU_NUM      = 4,
  parameter int CDB_NUM     = 2,
  parameter int XLEN        = 32,
  parameter int PREG_NUMBER = 64
) (
  input logic clk,
  input logic reset,
  cdb_complete_arbiter_if.slave bus
);
  localparam int TW = $clog2(PREG_NUMBER);
  localparam int PW = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
`ifdef CDB_FU0_PRIORITY_EN
  localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
  localparam logic [PW-1:0] PTR_RST = '0;
`endif

  logic [PW-1:0]                ptr_q, ptr_d;
  logic [FU_NUM-1:0]            gnt;
  logic [CDB_NUM-1:0][PW-1:0]   sel;
  logic [CDB_NUM-1:0]           sel_vld;
  logic [CDB_NUM-1:0]           valid_q, valid_d;
  logic [CDB_NUM-1:0]           wr_q, wr_d;
  logic [CDB_NUM-1:0][TW-1:0]   tag_q, tag_d;
  logic [CDB_NUM-1:0][XLEN-1:0] value_q, value_d;

  always_comb begin : grant_scan
    int cnt;
    int idx;
    int last;
    logic found;
    gnt     = '0;
    sel     = '0;
    sel_vld = '0;
    ptr_d   = ptr_q;
    cnt     = 0;
    idx     = 0;
    last    = 0;
    found   = 1'b0;
    if (!reset && !bus.branch_recover_i[0]) begin
`ifdef CDB_FU0_PRIORITY_EN
      if (bus.fu_done_i[0]) begin
        gnt[0]     = 1'b1;
        sel[0]     = '0;
        sel_vld[0] = 1'b1;
        cnt        = 1;
      end
      // The pointer lives in 1..FU_NUM-1, so the scan wraps over FU_NUM-1 entries.
      for (int k = 0; k < FU_NUM - 1; k++) begin
        idx = int'(ptr_q) - 1 + k;
        if (idx >= FU_NUM - 1) idx = idx - (FU_NUM - 1);
        idx = idx + 1;
        if (bus.fu_done_i[idx] && cnt < CDB_NUM) begin
          gnt[idx]     = 1'b1;
          sel[cnt]     = PW'(idx);
          sel_vld[cnt] = 1'b1;
          cnt          = cnt + 1;
          last         = idx;
          found        = 1'b1;
        end
      end
      if (found) ptr_d = (last == FU_NUM - 1) ? PW'(1) : PW'(last + 1);
`else
      for (int k = 0; k < FU_NUM; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= FU_NUM) idx = idx - FU_NUM;
        if (bus.fu_done_i[idx] && cnt < CDB_NUM) begin
          gnt[idx]     = 1'b1;
          sel[cnt]     = PW'(idx);
          sel_vld[cnt] = 1'b1;
          cnt          = cnt + 1;
          last         = idx;
          found        = 1'b1;
        end
      end
      if (found) ptr_d = (last == FU_NUM - 1) ? '0 : PW'(last + 1);
`endif
    end
  end

  always_comb begin : lane_next
    valid_d = '0;
    wr_d    = '0;
    tag_d   = '0;
    value_d = '0;
    for (int k = 0; k < CDB_NUM; k++) begin
      if (sel_vld[k]) begin
        valid_d[k] = 1'b1;
        wr_d[k]    = bus.fu_wr_en_i[sel[k]];
        tag_d[k]   = bus.fu_dest_reg_i[sel[k]];
        value_d[k] = bus.fu_result_i[sel[k]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= PTR_RST;
      valid_q <= '0;
      wr_q    <= '0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      wr_q    <= wr_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign bus.fu_complete_en_o = gnt;
  assign bus.cdb_valid_o      = valid_q;
  assign bus.cdb_wr_en_o      = wr_q;
  assign bus.cdb_tag_o        = tag_q;
  assign bus.cdb_value_o      = value_q;
  assign bus.ptr_o            = ptr_q;
endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Self-checking bench for cdb_complete_arbiter: directed scenarios followed by random traffic against a queue-based reference model.
module tb_cdb_complete_arbiter;
  localparam int FU_NUM      = 4;
  localparam int CDB_NUM     = 2;
  localparam int XLEN        = 32;
  localparam int PREG_NUMBER = 64;
  localparam int TW          = $clog2(PREG_NUMBER);
  localparam int LW          = 2 + TW + XLEN;
`ifdef CDB_FU0_PRIORITY_EN
  localparam int PTR_RST = 1;
`else
  localparam int PTR_RST = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_complete_arbiter_if #(.FU_NUM(FU_NUM), .CDB_NUM(CDB_NUM), .XLEN(XLEN), .PREG_NUMBER(PREG_NUMBER)) bus ();

  cdb_complete_arbiter #(.FU_NUM(FU_NUM), .CDB_NUM(CDB_NUM), .XLEN(XLEN), .PREG_NUMBER(PREG_NUMBER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr  = PTR_RST;
  logic [LW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    bus.fu_done_i        = '0;
    bus.branch_recover_i = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      bus.fu_result_i[i]   = '0;
      bus.fu_dest_reg_i[i] = '0;
      bus.fu_wr_en_i[i]    = 1'b0;
    end
  endtask

  task automatic set_fu(input int i, input logic d, input logic [XLEN-1:0] r,
                        input logic [TW-1:0] t, input logic w);
    bus.fu_done_i[i]     = d;
    bus.fu_result_i[i]   = r;
    bus.fu_dest_reg_i[i] = t;
    bus.fu_wr_en_i[i]    = w;
  endtask

  // One clock: check same-cycle grants against the model, then the lanes after the edge.
  task automatic run_cycle();
    int gq[$];
    int idx;
    int last;
    logic [FU_NUM-1:0] eg;
    logic [LW-1:0] w;
    @(negedge clk);
    gq = {};
    eg = '0;
    if (!reset && !bus.branch_recover_i[0]) begin
`ifdef CDB_FU0_PRIORITY_EN
      if (bus.fu_done_i[0]) gq.push_back(0);
      for (int k = 0; k < FU_NUM - 1; k++) begin
        idx = 1 + (m_ptr - 1 + k) % (FU_NUM - 1);
        if (bus.fu_done_i[idx]) gq.push_back(idx);
      end
`else
      for (int k = 0; k < FU_NUM; k++) begin
        idx = (m_ptr + k) % FU_NUM;
        if (bus.fu_done_i[idx]) gq.push_back(idx);
      end
`endif
      while (gq.size() > CDB_NUM) void'(gq.pop_back());
    end
    foreach (gq[j]) eg[gq[j]] = 1'b1;
    chk("complete_en", 64'(bus.fu_complete_en_o), 64'(eg));
    chk("ptr", 64'(bus.ptr_o), 64'(m_ptr));
    for (int k = 0; k < CDB_NUM; k++) begin
      if (k < gq.size())
        exp_q.push_back({1'b1, bus.fu_wr_en_i[gq[k]], bus.fu_dest_reg_i[gq[k]], bus.fu_result_i[gq[k]]});
      else
        exp_q.push_back('0);
    end
    if (reset) m_ptr = PTR_RST;
    else if (gq.size() > 0) begin
      last = gq[gq.size() - 1];
`ifdef CDB_FU0_PRIORITY_EN
      if (last != 0) m_ptr = (last % (FU_NUM - 1)) + 1;
`else
      m_ptr = (last + 1) % FU_NUM;
`endif
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < CDB_NUM; k++) begin
      w = exp_q.pop_front();
      chk($sformatf("lane%0d", k),
          64'({bus.cdb_valid_o[k], bus.cdb_wr_en_o[k], bus.cdb_tag_o[k], bus.cdb_value_o[k]}),
          64'(w));
    end
  endtask

  initial begin
    int ptr_before;
    reset = 1'b1;
    clear_inputs();
    bus.fu_done_i = '1;
    repeat (2) @(posedge clk);
    #1;
    // reset state: grants suppressed even with every FU done
    chk("rst_complete_en", 64'(bus.fu_complete_en_o), 64'd0);
    chk("rst_valid", 64'(bus.cdb_valid_o), 64'd0);
    chk("rst_tag", 64'(bus.cdb_tag_o), 64'd0);
    chk("rst_value", 64'(bus.cdb_value_o), 64'd0);
    chk("rst_wr_en", 64'(bus.cdb_wr_en_o), 64'd0);
    chk("rst_ptr", 64'(bus.ptr_o), 64'(PTR_RST));
    reset = 1'b0;
    clear_inputs();

    // basic grant and broadcast
    set_fu(2, 1'b1, 32'h1234, 6'd7, 1'b1);
    run_cycle();
    chk("s1_lane0", 64'({bus.cdb_valid_o[0], bus.cdb_tag_o[0], bus.cdb_value_o[0]}), 64'({1'b1, 6'd7, 32'h1234}));
    chk("s1_ptr", 64'(bus.ptr_o), 64'd3);

    // wrap-around from ptr=3
    clear_inputs();
    set_fu(3, 1'b1, 32'hAAAA_0003, 6'd33, 1'b1);
    set_fu(1, 1'b1, 32'hAAAA_0001, 6'd31, 1'b0);
    run_cycle();
    chk("s3_lane0_tag", 64'(bus.cdb_tag_o[0]), 64'd33);
    chk("s3_lane1_tag", 64'(bus.cdb_tag_o[1]), 64'd31);
    chk("s3_lane1_wr", 64'(bus.cdb_wr_en_o[1]), 64'd0);
    chk("s3_ptr", 64'(bus.ptr_o), 64'd2);

    // all FUs continuously done
    clear_inputs();
    for (int i = 0; i < FU_NUM; i++) set_fu(i, 1'b1, 32'hBEEF_0000 + i, 6'(10 + i), 1'b1);
    run_cycle();
    for (int c = 0; c < 4; c++) begin
      run_cycle();
`ifdef CDB_FU0_PRIORITY_EN
      chk("s5_lane0_tag", 64'(bus.cdb_tag_o[0]), 64'd10);
`else
      chk("s2_lane0_tag", 64'(bus.cdb_tag_o[0]), (c % 2 == 0) ? 64'd10 : 64'd12);
`endif
    end

    // branch recovery squashes grants and new latching
    clear_inputs();
    set_fu(0, 1'b1, 32'h1, 6'd1, 1'b1);
    set_fu(1, 1'b1, 32'h2, 6'd2, 1'b1);
    bus.branch_recover_i = 2'b01;
    ptr_before = int'(bus.ptr_o);
    run_cycle();
    chk("s4_valid", 64'(bus.cdb_valid_o), 64'd0);
    chk("s4_ptr", 64'(bus.ptr_o), 64'(ptr_before));
    bus.branch_recover_i = 2'b00;
    run_cycle();
    chk("s4_latched_valid", 64'(bus.cdb_valid_o), 64'd3);
    bus.branch_recover_i = 2'b01;
    run_cycle();
    chk("s4_after_recover", 64'(bus.cdb_valid_o), 64'd0);
    bus.branch_recover_i = 2'b00;

    // random traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < FU_NUM; i++)
        set_fu(i, 1'($urandom_range(0, 1)), $urandom, TW'($urandom_range(0, PREG_NUMBER - 1)), 1'($urandom_range(0, 1)));
      bus.branch_recover_i = ($urandom_range(0, 9) == 0) ? 2'b01 : {1'($urandom_range(0, 1)), 1'b0};
      run_cycle();
    end

    // reset asserted the cycle after a grant
    clear_inputs();
    set_fu(1, 1'b1, 32'hCAFE, 6'd21, 1'b1);
    run_cycle();
    reset = 1'b1;
    run_cycle();
    chk("s6_valid", 64'(bus.cdb_valid_o), 64'd0);
    chk("s6_value", 64'(bus.cdb_value_o), 64'd0);
    chk("s6_ptr", 64'(bus.ptr_o), 64'(PTR_RST));
    reset = 1'b0;
    clear_inputs();
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_complete_arbiter.md
# cdb_complete_arbiter

Shares the common data bus (CDB) between the execute-stage functional units (ALUs and similar single-result FUs). Each cycle it selects up to `CDB_NUM` FUs asserting `done` and returns a combinational per-FU `complete_en` in the same cycle. That `complete_en` clears the FU's done/ready state and enables its register-file write. The granted results are broadcast on registered CDB lanes one cycle later. Fairness comes from a round-robin priority pointer, and branch recovery squashes grants and in-flight broadcasts.

## Interface
Parameters:
- `FU_NUM`, default 4: number of requesting FUs, ≥ 2.
- `CDB_NUM`, default 2: CDB lanes (grants per cycle), 1 ≤ `CDB_NUM` ≤ `FU_NUM`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `fu_done_i`  in  `FU_NUM`  FU i holds a finished result.
- `fu_result_i`  in  `FU_NUM`×`XLEN`  result of FU i.
- `fu_dest_reg_i`  in  `FU_NUM`×$clog2(`PREG_NUMBER)  destination physical register of FU i.
- `fu_wr_en_i`  in  `FU_NUM`  FU i writes a register (dest sel == DEST_RD).
- `branch_recover_i`  in  2  bit 0 = squash all in-flight work.
- `fu_complete_en_o`  out  `FU_NUM`  combinational grant to FU i, driven to the FU's `complete_en_i`.
- `cdb_valid_o`  out  `CDB_NUM`  lane k broadcasting.
- `cdb_tag_o`  out  `CDB_NUM`×$clog2(`PREG_NUMBER)  broadcast preg.
- `cdb_value_o`  out  `CDB_NUM`×`XLEN`  broadcast value.
- `cdb_wr_en_o`  out  `CDB_NUM`  lane writes a register (tag wakeup only when 1).

## Operation
- Priority pointer `ptr` has range 0..`FU_NUM`-1; its reset value is 0.
- Grant scan: visit FUs in order `ptr`, `ptr`+1, …, wrapping modulo `FU_NUM`. The first `CDB_NUM` FUs with `fu_done_i`=1 are granted.
  - The first granted FU is assigned lane 0, the next lane 1, and so on.
  - Unused lanes are idle.
- `fu_complete_en_o[i]` = 1 exactly for granted FUs. It is purely combinational from `fu_done_i`, `ptr` and `branch_recover_i`.
- Pointer update:
  - If ≥1 FU was granted: `ptr` ← (index of last granted FU + 1) mod `FU_NUM`.
  - If no FU was granted: `ptr` holds.
- Lane registers: at each edge, lane k latches valid, tag, value and wr_en from its granted FU. Lanes without a grant latch valid=0, tag=0, value=0, wr_en=0.
- Branch recover (`branch_recover_i[0]`=1):
  - `fu_complete_en_o` is forced to 0.
  - All lanes latch invalid at the next edge.
  - `ptr` holds.
  - The recovering FUs drop done themselves; the arbiter does not track them.
- An FU whose done stays high because it executed again in its grant cycle is treated as a new request. No duplicate filtering is performed.

## Timing
- Grant latency: 0 cycles, so `fu_complete_en_o` is valid in the same cycle as `fu_done_i`.
- Broadcast latency: 1 cycle, so `cdb_*` is valid the cycle after the grant, for exactly one cycle per grant.
- Reset values: `cdb_valid_o`=0, `cdb_tag_o`=0, `cdb_value_o`=0, `cdb_wr_en_o`=0, `ptr`=0. `fu_complete_en_o`=0 while `reset`=1.
- Reset asserted mid-stream: pending lane contents are discarded at the edge. No broadcast occurs in the following cycle.
- Worst-case wait for a continuously-done FU is ⌈`FU_NUM`/`CDB_NUM`⌉−1 cycles. With `CDB_FU0_PRIORITY_EN`, FU0's traffic can stretch this for the other FUs.
- When more than `CDB_NUM` FUs are done, losers keep done asserted (the FU holds `ready_o`=0). The arbiter needs no queue.

## Configuration
- Macro: `CDB_FU0_PRIORITY_EN`.
- When defined, FU0 (branch/critical unit):
  - is always considered first, before the round-robin scan;
  - takes lane 0 whenever `fu_done_i[0]`=1;
  - is excluded from the round-robin scan, which fills the remaining lanes from the other FUs.
  - `ptr` then ranges over 1..`FU_NUM`-1, resets to 1, and is updated only by non-FU0 grants.
- When undefined, all FUs are equal in round-robin as described above.

## Test plan
All scenarios use `FU_NUM`=4, `CDB_NUM`=2 and macro off, except scenario 5.
1. Basic grant and broadcast.
   - Stimulus: after reset, FU2 done with result 0x1234, dest 7, wr_en 1.
   - Response: `fu_complete_en_o`=0100 in the same cycle. Next cycle lane 0 has valid=1, tag=7, value=0x1234. `ptr`=3.
2. Round-robin fairness.
   - Stimulus: all four FUs done continuously, `ptr`=0.
   - Response: grants 0011, 1100, 0011, … alternate. Lane 0 carries FU0, then FU2. No FU waits more than 1 cycle.
3. Wrap-around.
   - Stimulus: `ptr`=3; FU3 and FU1 done.
   - Response: lane 0 = FU3, lane 1 = FU1. `ptr` becomes 2.
4. Branch recovery.
   - Stimulus: FU0 and FU1 done with `branch_recover_i`=01.
   - Response: `fu_complete_en_o`=0000; `cdb_valid_o`=00 next cycle; `ptr` unchanged.
   - Stimulus: a lane was valid when recovery was asserted.
   - Response: that lane still broadcasts its already-latched result, because recovery only blocks new latching.
5. Priority macro.
   - Stimulus: `CDB_FU0_PRIORITY_EN` defined; all FUs done for 3 cycles.
   - Response: lane 0 = FU0 every cycle. Lane 1 cycles FU1, FU2, FU3.
6. Reset mid-stream.
   - Stimulus: `reset` asserted in the cycle after a grant.
   - Response: all `cdb_*` outputs are 0 at the next edge. `ptr`=0.
